strpad_stream: RTL and testbench

Streaming, parametrised successor to the fixed-function left-pad engine. Accepts a command (length, desired width, pad character, mode) over a valid/ready channel, buffers the input string one character per beat, then emits the padded or truncated result one character per beat with back-pressure. It supports left and right justification and optional truncation, and sits between a character source and a character sink in the string-formatting datapath.

---
 rtl/strpad_stream.sv | 167 ++++++++++++++++
 tb/tb_strpad_stream.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/strpad_stream.sv
// Buffers a string of up to STR_LEN_MAX characters, then streams it out left- or right-justified
// inside a field of the requested width, padding or truncating as commanded.
module strpad_stream #(
  parameter int STR_LEN_MAX = 8,
  parameter int CHAR_W      = 8,
  localparam int LEN_W      = $clog2(STR_LEN_MAX + 1),
  localparam int DES_W      = $clog2(2 * STR_LEN_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LEN_W-1:0]  cmd_strlen_i,
  input  logic [DES_W-1:0]  cmd_desired_i,
  input  logic [CHAR_W-1:0] cmd_pad_i,
  input  logic              cmd_mode_i,
  input  logic              cmd_trunc_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CHAR_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CHAR_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o
);
  localparam int IDX_W = (STR_LEN_MAX > 1) ? $clog2(STR_LEN_MAX) : 1;

  typedef enum logic [1:0] {INIT, IDLE, LOAD, EMIT} state_t;
  typedef logic [STR_LEN_MAX-1:0][CHAR_W-1:0] buf_t;

  state_t             state_q;
  logic [LEN_W-1:0]   s_q, widx_q, widx_d, s_sat;
  logic [DES_W-1:0]   p_q, l_q, sp_q, k_q, k_d;
  logic [DES_W-1:0]   d_sat, s_ext, p_d, l_d, sp_d;
  logic [CHAR_W-1:0]  pad_q, out_data_q;
  logic               mode_q;
  logic               cmd_ready_q, in_ready_q, out_valid_q, out_last_q, busy_q;
  logic               cmd_hs, ld_hs, out_hs;
  buf_t               buf_q, buf_d;

  // Character at output position k: pads first in left mode, string first in right mode.
  function automatic logic [CHAR_W-1:0] char_at(input logic [DES_W-1:0] k, input logic mode,
                                                input logic [DES_W-1:0] p, input logic [DES_W-1:0] sp,
                                                input logic [CHAR_W-1:0] pad, input buf_t bufv);
    if (!mode) return (k < p) ? pad : bufv[IDX_W'(k - p)];
    else       return (k < sp) ? bufv[IDX_W'(k)] : pad;
  endfunction

  assign cmd_hs = cmd_ready_q & cmd_valid_i;
  assign ld_hs  = in_ready_q & in_valid_i;
  assign out_hs = out_valid_q & out_ready_i;

  always_comb begin
    s_sat  = (cmd_strlen_i > LEN_W'(STR_LEN_MAX)) ? LEN_W'(STR_LEN_MAX) : cmd_strlen_i;
    d_sat  = (cmd_desired_i > DES_W'(2 * STR_LEN_MAX)) ? DES_W'(2 * STR_LEN_MAX) : cmd_desired_i;
    s_ext  = DES_W'(s_sat);
    p_d    = (d_sat > s_ext) ? d_sat - s_ext : '0;
    l_d    = cmd_trunc_i ? d_sat : ((s_ext > d_sat) ? s_ext : d_sat);
    sp_d   = (s_ext < l_d) ? s_ext : l_d;
    k_d    = k_q + DES_W'(1);
    widx_d = widx_q + LEN_W'(1);
    // Bypass the beat being written so the first output character is ready on EMIT entry.
    buf_d  = buf_q;
    if (ld_hs) buf_d[widx_q[IDX_W-1:0]] = in_data_i;
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      s_q         <= '0;
      widx_q      <= '0;
      p_q         <= '0;
      l_q         <= '0;
      sp_q        <= '0;
      k_q         <= '0;
      pad_q       <= '0;
      mode_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        IDLE: begin
          if (cmd_hs) begin
            s_q    <= s_sat;
            p_q    <= p_d;
            l_q    <= l_d;
            sp_q   <= sp_d;
            pad_q  <= cmd_pad_i;
            mode_q <= cmd_mode_i;
            widx_q <= '0;
            k_q    <= '0;
            if (s_sat != '0) begin
              state_q     <= LOAD;
              cmd_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
            end else if (l_d != '0) begin
              state_q     <= EMIT;
              cmd_ready_q <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= cmd_pad_i;
              out_last_q  <= (l_d == DES_W'(1));
              busy_q      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_hs) begin
            widx_q <= widx_d;
            if (widx_d == s_q) begin
              widx_q     <= '0;
              in_ready_q <= 1'b0;
              if (l_q != '0) begin
                state_q     <= EMIT;
                out_valid_q <= 1'b1;
                out_data_q  <= char_at('0, mode_q, p_q, sp_q, pad_q, buf_d);
                out_last_q  <= (l_q == DES_W'(1));
              end else begin
                state_q     <= IDLE;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end else begin
              k_q        <= k_d;
              out_data_q <= char_at(k_d, mode_q, p_q, sp_q, pad_q, buf_q);
              out_last_q <= (k_d == l_q - DES_W'(1));
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_strpad_stream.sv
// Bench for strpad_stream: directed cases plus randomized commands against a string-level model.
module tb_strpad_stream;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid_i, cmd_ready_o, cmd_mode_i, cmd_trunc_i;
  logic [3:0] cmd_strlen_i;
  logic [4:0] cmd_desired_i;
  logic [7:0] cmd_pad_i, in_data_i, out_data_o;
  logic       in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_last_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] str_mem [8];
  logic [7:0] exp_q [$];

  strpad_stream dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_strlen_i(cmd_strlen_i),
    .cmd_desired_i(cmd_desired_i), .cmd_pad_i(cmd_pad_i), .cmd_mode_i(cmd_mode_i),
    .cmd_trunc_i(cmd_trunc_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_str(input string s);
    for (int i = 0; i < 8; i++) str_mem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // Expected output as a character sequence built from the justification rules.
  task automatic build_model(input int ss, input int dd, input logic [7:0] pad,
                             input bit mode, input bit trunc);
    int npad;
    exp_q.delete();
    if (trunc && dd < ss) begin
      for (int i = 0; i < dd; i++) exp_q.push_back(str_mem[i]);
    end else begin
      npad = (dd > ss) ? dd - ss : 0;
      if (!mode) for (int i = 0; i < npad; i++) exp_q.push_back(pad);
      for (int i = 0; i < ss; i++) exp_q.push_back(str_mem[i]);
      if (mode) for (int i = 0; i < npad; i++) exp_q.push_back(pad);
    end
  endtask

  // Issues the command at a negedge where cmd_ready is high; returns at the following negedge.
  task automatic issue_cmd(input int s_raw, input int d_raw, input logic [7:0] pad,
                           input bit mode, input bit trunc);
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", n < 50, 1);
    cmd_valid_i   = 1'b1;
    cmd_strlen_i  = 4'(s_raw);
    cmd_desired_i = 5'(d_raw);
    cmd_pad_i     = pad;
    cmd_mode_i    = mode;
    cmd_trunc_i   = trunc;
    @(negedge clk);
    cmd_valid_i   = 1'b0;
    cmd_strlen_i  = 4'($urandom);
    cmd_desired_i = 5'($urandom);
    cmd_pad_i     = 8'($urandom);
    cmd_mode_i    = 1'($urandom);
    cmd_trunc_i   = 1'($urandom);
  endtask

  // stall_pct < 0 selects a strict 1,0,1,0 out_ready pattern.
  task automatic run_txn(input int s_raw, input int d_raw, input logic [7:0] pad,
                         input bit mode, input bit trunc, input int gap_pct, input int stall_pct);
    int ss, dd, len, cyc, ib, ob, gaps, stalls;
    bit done, prev_stall, tog, rdy;
    logic [7:0] prev_d;
    logic prev_l;
    ss = (s_raw > 8) ? 8 : s_raw;
    dd = (d_raw > 16) ? 16 : d_raw;
    build_model(ss, dd, pad, mode, trunc);
    len = exp_q.size();
    issue_cmd(s_raw, d_raw, pad, mode, trunc);
    cyc = 1; ib = 0; ob = 0; gaps = 0; stalls = 0;
    done = 0; prev_stall = 0; tog = 1; prev_d = 0; prev_l = 0;
    while (!done && cyc < 400) begin
      if (cmd_ready_o === 1'b1) begin
        done = 1;
      end else begin
        check("busy", busy_o, 1);
        if (in_ready_o) begin
          if (int'($urandom_range(99)) < gap_pct) begin
            in_valid_i = 1'b0;
            gaps++;
          end else begin
            in_valid_i = 1'b1;
            in_data_i  = (ib < 8) ? str_mem[ib] : 8'h00;
            ib++;
          end
        end else begin
          in_valid_i = 1'($urandom);
          in_data_i  = 8'($urandom);
        end
        if (out_valid_o) begin
          if (prev_stall) begin
            check("stall_data", out_data_o, prev_d);
            check("stall_last", out_last_o, prev_l);
          end
          if (ob < len) check("out_data", out_data_o, exp_q[ob]);
          else          check("extra_out", ob, len);
          check("out_last", out_last_o, ob == len - 1);
          rdy = (stall_pct < 0) ? tog : (int'($urandom_range(99)) >= stall_pct);
          tog = !tog;
          out_ready_i = rdy;
          if (rdy) ob++;
          else     stalls++;
          prev_stall = !rdy;
          prev_d = out_data_o;
          prev_l = out_last_o;
        end else begin
          check("idle_out_data", out_data_o, 0);
          out_ready_i = 1'($urandom);
          prev_stall = 0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    check("txn_timeout", done, 1);
    check("in_beats", ib, ss);
    check("out_beats", ob, len);
    check("end_cycle", cyc, ss + len + 1 + gaps + stalls);
  endtask

  initial begin
    int ob, n;
    rst_n = 1'b0;
    cmd_valid_i = 0; cmd_strlen_i = 0; cmd_desired_i = 0; cmd_pad_i = 0;
    cmd_mode_i = 0; cmd_trunc_i = 0; in_valid_i = 0; in_data_i = 0; out_ready_i = 0;
    #3;
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_out_data", out_data_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_cmd_ready", cmd_ready_o, 0);
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready_o, 1);

    set_str("foo");    run_txn(3, 5, "!", 0, 0, 0, 0);
    set_str("foo");    run_txn(3, 5, ".", 1, 0, 0, 0);
    set_str("abcdef"); run_txn(6, 3, "-", 0, 1, 0, 0);
    set_str("abcdef"); run_txn(6, 3, "-", 1, 1, 0, 0);
    set_str("abcdef"); run_txn(6, 3, "-", 0, 0, 0, 0);
    set_str("");       run_txn(0, 0, "#", 0, 0, 0, 0);
    set_str("");       run_txn(0, 2, "*", 0, 0, 0, 0);
    set_str("ab");     run_txn(2, 0, "+", 1, 1, 0, 0);
    set_str("foo");    run_txn(3, 5, "!", 0, 0, 40, -1);
    set_str("x");      run_txn(1, 1, "_", 0, 0, 0, 0);
    set_str("abcdefgh"); run_txn(15, 31, "=", 1, 0, 20, 30);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) str_mem[i] = 8'($urandom_range(8'h7e, 8'h21));
      run_txn($urandom_range(15), $urandom_range(31), 8'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(40), $urandom_range(40));
    end

    // Reset while the second output character is presented.
    set_str("foo");
    issue_cmd(3, 5, "!", 0, 0);
    ob = 0; n = 0;
    out_ready_i = 1'b1;
    while (!(out_valid_o && ob == 1) && n < 40) begin
      in_valid_i = in_ready_o;
      in_data_i  = str_mem[dut.widx_q[2:0]];
      if (out_valid_o) begin
        check("pre_rst_char", out_data_o, "!");
        ob++;
      end
      @(negedge clk);
      n++;
    end
    check("reach_2nd_char", n < 40, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid_o, 0);
    check("mid_rst_out_last", out_last_o, 0);
    check("mid_rst_out_data", out_data_o, 0);
    check("mid_rst_cmd_ready", cmd_ready_o, 0);
    check("mid_rst_busy", busy_o, 0);
    in_valid_i = 0; out_ready_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rec_init_cmd_ready", cmd_ready_o, 0);
    @(negedge clk);
    check("rec_idle_cmd_ready", cmd_ready_o, 1);
    set_str("ab");     run_txn(2, 4, "~", 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
